onehot_mux_reg: RTL
===================

ONEHOT_MUX_REG -- requirements
Module: onehot_mux_reg

Interface
REQ-001 Parameter N_CH, default 4: number of input channels; legal range 2..32.
REQ-002 Parameter DW, default 1: data width per channel; legal range 1..64.
REQ-003 Parameter HOLD_CYC, default 0: minimum dwell cycles after a select is accepted; legal range 0..255.
REQ-004 Parameter DEFAULT_CH, default N_CH-1: channel used for an illegal select; must be < N_CH.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  reset, asynchronous and active-low.
REQ-007 data_in  input  N_CH*DW  packed channels; channel i occupies bits [i*DW +: DW].
REQ-008 sel  input  N_CH  one-hot select request; bit i selects channel i.
REQ-009 sel_valid  input  1  sel request valid.
REQ-010 sel_ready  output  1  block can accept a select request.
REQ-011 err_clr  input  1  clears sel_err.
REQ-012 data_out  output  DW  registered selected data.
REQ-013 out_valid  output  1  data_out holds data from a selected channel.
REQ-014 cur_sel  output  $clog2(N_CH)  index of the channel currently selected.
REQ-015 sel_err  output  1  sticky flag: an illegal select was accepted.
REQ-016 err_cnt  output  8  count of illegal selects accepted; saturates at 255.

Function
REQ-017 States: NOSEL (reset; nothing selected), LOCKED (dwell running), OPEN (selected; accepting).
REQ-018 sel_ready shall be 1 in NOSEL and OPEN and 0 in LOCKED.
REQ-019 Accept occurs when sel_valid=1 and sel_ready=1 on a rising edge; sel is ignored at all other times.
REQ-020 Accept with exactly one bit of sel set: cur_sel takes that bit's index.
REQ-021 Accept with sel zero or multi-hot: cur_sel takes DEFAULT_CH, sel_err is set, and err_cnt increments unless already 255.
REQ-022 On accept with HOLD_CYC=0, the next state is OPEN; otherwise the next state is LOCKED with the dwell counter loaded to HOLD_CYC.
REQ-023 In LOCKED the dwell counter decrements each cycle; when it reaches 1, the next state is OPEN. sel_ready is therefore 0 for exactly HOLD_CYC cycles after the accept edge.
REQ-024 Each edge in OPEN or LOCKED, data_out is loaded from channel cur_sel of the current data_in.
REQ-025 On the accept edge, data_out is loaded from the newly decoded channel. Data latency from the accept is one cycle.
REQ-026 out_valid goes to 1 on the first accept edge and stays 1 until reset.
REQ-027 In NOSEL, data_out is held at 0.
REQ-028 err_clr=1 clears sel_err and leaves err_cnt unchanged.
REQ-029 If err_clr coincides with an illegal accept, sel_err ends at 1 (set wins).
REQ-030 A new accept in OPEN switches channels with no intermediate value on data_out.

Reset
REQ-031 While rst_n=0, outputs are: data_out=0, out_valid=0, cur_sel=0, sel_err=0, err_cnt=0, sel_ready=1, state NOSEL, dwell counter 0.
REQ-032 Reset assertion mid-LOCKED or mid-switch aborts immediately; no pending select survives reset.
REQ-033 After rst_n deasserts, the first edge with sel_valid=1 is accepted.

Structure
REQ-034 Package onehot_mux_pkg holds the state enum (NOSEL, LOCKED, OPEN) and the err_cnt width/saturation constant.
REQ-035 Sub-module onehot_enc (sel -> index plus legal flag, purely combinational) is instantiated once; all state lives in onehot_mux_reg.

Verification
REQ-036 Defaults; reset; sel=0001 with valid; data_in ch0=1 -> next edge data_out=1, out_valid=1, cur_sel=0.
REQ-037 N_CH=4, DW=8; sel=0110 accepted -> cur_sel=3, data_out=ch3 byte, sel_err=1, err_cnt=1.
REQ-038 HOLD_CYC=3; accept 0010 then hold sel_valid with 0100 -> sel_ready low for 3 cycles; 0100 accepted on the 4th edge.
REQ-039 Illegal accept with err_clr=1 in the same cycle -> sel_err=1. err_clr alone next cycle -> sel_err=0, err_cnt unchanged.
REQ-040 Run 260 illegal accepts -> err_cnt=255 and holds. Assert rst_n low mid-LOCKED -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/onehot_mux_pkg.sv
// Shared types and constants for the one-hot registered channel mux.
package onehot_mux_pkg;

  // Control states: nothing selected yet, dwell running, selected and accepting.
  typedef enum logic [1:0] {
    NOSEL  = 2'd0,
    LOCKED = 2'd1,
    OPEN   = 2'd2
  } mux_state_e;

  // Illegal-select counter width and its saturation value.
  localparam int                   ERR_CNT_W   = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'd255;

  // Width of the dwell counter; covers the whole HOLD_CYC range 0..255.
  localparam int DWELL_W = 8;

  // Saturating increment for the illegal-select counter.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] value);
    logic [ERR_CNT_W-1:0] result;
    if (value == ERR_CNT_MAX) begin
      result = value;
    end else begin
      result = value + 8'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/onehot_enc.sv
// One-hot select decoder: returns the index of the set bit and whether
// exactly one bit is set. Purely combinational.
module onehot_enc #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  sel,
  output logic [IW-1:0] idx,
  output logic          legal
);

  // Population count wide enough to hold N set bits.
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [CW-1:0] ones_s;

  // Count the set bits and remember the position of the (last) set bit.
  always_comb begin
    ones_s = {CW{1'b0}};
    idx    = {IW{1'b0}};
    for (int i = 0; i < N; i++) begin
      ones_s = ones_s + {{(CW-1){1'b0}}, sel[i]};
      idx    = sel[i] ? IW'(i) : idx;
    end
    legal = (ones_s == ONE);
  end

endmodule

// File: rtl/onehot_mux_reg.sv
// Registered one-hot channel multiplexer with optional dwell time after each
// accepted select, default-channel fallback for illegal selects, and a sticky
// error flag plus saturating error counter.
module onehot_mux_reg
  import onehot_mux_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int DW         = 1,
  parameter int HOLD_CYC   = 0,
  parameter int DEFAULT_CH = N_CH - 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH*DW-1:0]      data_in,
  input  logic [N_CH-1:0]         sel,
  input  logic                    sel_valid,
  output logic                    sel_ready,
  input  logic                    err_clr,
  output logic [DW-1:0]           data_out,
  output logic                    out_valid,
  output logic [$clog2(N_CH)-1:0] cur_sel,
  output logic                    sel_err,
  output logic [ERR_CNT_W-1:0]    err_cnt
);

  localparam int                 IW       = $clog2(N_CH);
  localparam logic [IW-1:0]      DEF_IDX  = IW'(DEFAULT_CH);
  localparam logic [DWELL_W-1:0] HOLD_LD  = DWELL_W'(HOLD_CYC);
  localparam logic [DWELL_W-1:0] DWELL_1  = 8'd1;
  localparam logic [DWELL_W-1:0] DWELL_0  = 8'd0;

  // Control state
  mux_state_e           state_r;
  mux_state_e           state_next_s;
  logic [DWELL_W-1:0]   dwell_r;
  logic [DWELL_W-1:0]   dwell_next_s;
  logic                 ready_r;
  logic                 ready_next_s;

  // Datapath registers and their next values
  logic [DW-1:0]        data_r;
  logic [DW-1:0]        data_next_s;
  logic                 valid_r;
  logic                 valid_next_s;
  logic [IW-1:0]        cur_r;
  logic [IW-1:0]        cur_next_s;
  logic                 err_r;
  logic                 err_next_s;
  logic [ERR_CNT_W-1:0] cnt_r;
  logic [ERR_CNT_W-1:0] cnt_next_s;

  // Decode and mux helpers
  logic [DW-1:0]        ch_s [N_CH];
  logic [IW-1:0]        enc_idx_s;
  logic                 enc_legal_s;
  logic [IW-1:0]        new_idx_s;
  logic [IW-1:0]        mux_idx_s;
  logic                 accept_s;

  // Split the packed input bus into per-channel words.
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign ch_s[g] = data_in[g*DW +: DW];
  end

  onehot_enc #(
    .N  (N_CH),
    .IW (IW)
  ) u_enc (
    .sel   (sel),
    .idx   (enc_idx_s),
    .legal (enc_legal_s)
  );

  // A request is taken only when we advertise readiness.
  assign accept_s  = sel_valid & ready_r;
  // Illegal selects fall back to the default channel.
  assign new_idx_s = enc_legal_s ? enc_idx_s : DEF_IDX;
  // On an accept the new channel feeds the output immediately.
  assign mux_idx_s = accept_s ? new_idx_s : cur_r;

  // State register: control state, dwell counter and registered ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= NOSEL;
      dwell_r <= DWELL_0;
      ready_r <= 1'b1;
    end else begin
      state_r <= state_next_s;
      dwell_r <= dwell_next_s;
      ready_r <= ready_next_s;
    end
  end

  // Next-state logic: accepts start a dwell (or go straight to OPEN), dwell counts down to OPEN.
  always_comb begin
    state_next_s = state_r;
    dwell_next_s = dwell_r;
    case (state_r)
      NOSEL, OPEN: begin
        if (accept_s) begin
          if (HOLD_CYC == 0) begin
            state_next_s = OPEN;
            dwell_next_s = DWELL_0;
          end else begin
            state_next_s = LOCKED;
            dwell_next_s = HOLD_LD;
          end
        end else begin
          state_next_s = state_r;
          dwell_next_s = dwell_r;
        end
      end
      LOCKED: begin
        if (dwell_r <= DWELL_1) begin
          state_next_s = OPEN;
          dwell_next_s = DWELL_0;
        end else begin
          state_next_s = LOCKED;
          dwell_next_s = dwell_r - DWELL_1;
        end
      end
      default: begin
        state_next_s = NOSEL;
        dwell_next_s = DWELL_0;
      end
    endcase
    ready_next_s = (state_next_s != LOCKED);
  end

  // Output logic: next values for the selected data, selection index and error tracking.
  always_comb begin
    cur_next_s   = cur_r;
    valid_next_s = valid_r;
    err_next_s   = err_r;
    cnt_next_s   = cnt_r;
    data_next_s  = {DW{1'b0}};

    if (accept_s) begin
      cur_next_s   = new_idx_s;
      valid_next_s = 1'b1;
    end else begin
      cur_next_s   = cur_r;
      valid_next_s = valid_r;
    end

    // An illegal accept sets the flag even when a clear arrives on the same edge.
    if (accept_s && !enc_legal_s) begin
      err_next_s = 1'b1;
      cnt_next_s = sat_inc(cnt_r);
    end else if (err_clr) begin
      err_next_s = 1'b0;
      cnt_next_s = cnt_r;
    end else begin
      err_next_s = err_r;
      cnt_next_s = cnt_r;
    end

    // Output follows the live channel once anything is selected; zero before that.
    if (accept_s || (state_r != NOSEL)) begin
      data_next_s = ch_s[mux_idx_s];
    end else begin
      data_next_s = {DW{1'b0}};
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r  <= {DW{1'b0}};
      valid_r <= 1'b0;
      cur_r   <= {IW{1'b0}};
      err_r   <= 1'b0;
      cnt_r   <= {ERR_CNT_W{1'b0}};
    end else begin
      data_r  <= data_next_s;
      valid_r <= valid_next_s;
      cur_r   <= cur_next_s;
      err_r   <= err_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  assign sel_ready = ready_r;
  assign data_out  = data_r;
  assign out_valid = valid_r;
  assign cur_sel   = cur_r;
  assign sel_err   = err_r;
  assign err_cnt   = cnt_r;

endmodule
